// File: rtl/slc3_trace_buffer_pkg.sv
// slc3_trace_pkg: shared FSM type and default parameters for the SLC-3 trace buffer.
package slc3_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trace_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_WRAP   = 0;
    localparam int TS_W       = 32;

endpackage

// File: rtl/slc3_trace_buffer_if.sv
// slc3_trace_buffer_if: capture, check and readout signals of the trace buffer.
// master = the agent driving captures/reads, slave = the trace buffer itself.
interface slc3_trace_buffer_if
    import slc3_trace_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic                     arm;
    logic                     stop;
    logic                     cap_en;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     exp_en;
    logic [NUM_CH*DATA_W-1:0] exp_data;
    logic [NUM_CH-1:0]        exp_mask;
    logic                     rd_req;
    logic                     rd_valid;
    logic [NUM_CH*DATA_W-1:0] rd_data;
    logic [TS_W-1:0]          rd_ts;
    logic [LW-1:0]            level;
    logic                     full;
    logic                     wrapped;
    logic [CNT_W-1:0]         error_cnt;
    logic [NUM_CH-1:0]        err_ch;
    logic                     busy;

    modport master (
        output arm, stop, cap_en, ch_data, exp_en, exp_data, exp_mask, rd_req,
        input  rd_valid, rd_data, rd_ts, level, full, wrapped, error_cnt, err_ch, busy
    );

    modport slave (
        input  arm, stop, cap_en, ch_data, exp_en, exp_data, exp_mask, rd_req,
        output rd_valid, rd_data, rd_ts, level, full, wrapped, error_cnt, err_ch, busy
    );
endinterface

// File: rtl/slc3_trace_ram.sv
// slc3_trace_ram: simple dual-port trace memory, one write port and a
// registered read port. Array contents are not reset; the read register is.
module slc3_trace_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Storage array write port.
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register loads on a read request and holds otherwise.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_addr];
    end

    // Read register with synchronous reset to zero.
    always_ff @(posedge Clk) begin
        if (Reset) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/slc3_trace_buffer.sv
// slc3_trace_buffer: samples NUM_CH watched SLC-3 registers into a DEPTH-entry
// trace memory, checks samples against expected values and counts mismatches.
// Optional feature: define SLC3_TRACE_TIMESTAMP_EN to store a 32-bit cycle
// timestamp with every entry (returned on rd_ts); otherwise rd_ts reads 0.
module slc3_trace_buffer
    import slc3_trace_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WRAP   = DEF_WRAP
) (
    input logic                Clk,
    input logic                Reset,
    slc3_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = NUM_CH * DATA_W;
`ifdef SLC3_TRACE_TIMESTAMP_EN
    localparam int MEM_W = DW + TS_W;
`else
    localparam int MEM_W = DW;
`endif

    trace_state_t      state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              wrapped_q, wrapped_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]  error_cnt_q, error_cnt_d;
    logic [NUM_CH-1:0] err_ch_q, err_ch_d;
    logic [NUM_CH-1:0] mism;
    logic              full, enter_cap, wr_en, rd_en;
    logic [MEM_W-1:0]  wr_word, rd_word;

    assign full      = (level_q == LW'(DEPTH));
    assign enter_cap = bus.arm && (state_q != CAPTURE);

`ifdef SLC3_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    // Free-running cycle counter, restarted when a capture session begins.
    always_comb begin
        ts_d = enter_cap ? '0 : ts_q + 1'b1;
    end

    // Timestamp counter register.
    always_ff @(posedge Clk) begin
        if (Reset) ts_q <= '0;
        else       ts_q <= ts_d;
    end

    assign wr_word     = {ts_q, bus.ch_data};
    assign bus.rd_data = rd_word[DW-1:0];
    assign bus.rd_ts   = rd_word[MEM_W-1:DW];
`else
    assign wr_word     = bus.ch_data;
    assign bus.rd_data = rd_word;
    assign bus.rd_ts   = '0;
`endif

    // Next-state, pointer, compare and counter logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        wrapped_d   = wrapped_q;
        error_cnt_d = error_cnt_q;
        err_ch_d    = err_ch_q;
        rd_valid_d  = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        mism        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mism[i] = bus.exp_mask[i] &&
                      (bus.ch_data[i*DATA_W +: DATA_W] != bus.exp_data[i*DATA_W +: DATA_W]);
        end

        if (enter_cap) begin
            // arm from IDLE or DONE starts a fresh session; it wins over rd_req.
            state_d     = CAPTURE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            wrapped_d   = 1'b0;
            error_cnt_d = '0;
            err_ch_d    = '0;
        end else if (state_q == CAPTURE) begin
            if (bus.cap_en) begin
                if (!full) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    level_d  = level_q + 1'b1;
                    if (WRAP == 0 && level_q == LW'(DEPTH - 1)) state_d = DONE;
                end else if (WRAP != 0) begin
                    // Overwrite the oldest entry; the read side skips past it.
                    wr_en     = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    wrapped_d = 1'b1;
                end
                if (bus.exp_en) begin
                    err_ch_d = err_ch_q | mism;
                    if ((|mism) && (error_cnt_q != '1)) error_cnt_d = error_cnt_q + 1'b1;
                end
            end
            if (bus.stop) state_d = DONE;
        end else if (state_q == DONE) begin
            if (bus.rd_req && (level_q != '0)) begin
                rd_en      = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                level_d    = level_q - 1'b1;
                rd_valid_d = 1'b1;
            end
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wrapped_q   <= 1'b0;
            error_cnt_q <= '0;
            err_ch_q    <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wrapped_q   <= wrapped_d;
            error_cnt_q <= error_cnt_d;
            err_ch_q    <= err_ch_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    slc3_trace_ram #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_word)
    );

    assign bus.rd_valid  = rd_valid_q;
    assign bus.level     = level_q;
    assign bus.full      = full;
    assign bus.wrapped   = wrapped_q;
    assign bus.error_cnt = error_cnt_q;
    assign bus.err_ch    = err_ch_q;
    assign bus.busy      = (state_q == CAPTURE);
endmodule

// File: tb/tb_slc3_trace_buffer.sv
// tb_slc3_trace_buffer: two trace buffers (DEPTH=4; u0 stop-when-full with a
// 16-bit error counter, u1 circular with a 2-bit counter) driven by the same
// stimulus and compared every cycle against a queue-based reference model.
module tb_slc3_trace_buffer;
    localparam int DEPTH = 4;
`ifdef SLC3_TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef logic [95:0] ent_t;   // {timestamp[31:0], data[63:0]}

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        arm = 1'b0, stop = 1'b0, cap_en = 1'b0, exp_en = 1'b0, rd_req = 1'b0;
    logic [63:0] ch_data = '0, exp_data = '0;
    logic [3:0]  exp_mask = '0;

    int checks = 0;
    int failures = 0;

    // Reference model state, one slot per DUT instance.
    int          m_state [2];   // 0 idle, 1 capturing, 2 done
    ent_t        m_q     [2][$];
    bit          m_wrapped [2];
    int          m_cnt   [2];
    logic [3:0]  m_errch [2];
    logic [31:0] m_ts    [2];
    bit          m_rv    [2];
    logic [63:0] m_rdata [2];
    logic [31:0] m_rts   [2];

    slc3_trace_buffer_if #(.DATA_W(16), .NUM_CH(4), .DEPTH(DEPTH), .CNT_W(16)) if0 ();
    slc3_trace_buffer_if #(.DATA_W(16), .NUM_CH(4), .DEPTH(DEPTH), .CNT_W(2))  if1 ();

    assign if0.arm = arm;       assign if1.arm = arm;
    assign if0.stop = stop;     assign if1.stop = stop;
    assign if0.cap_en = cap_en; assign if1.cap_en = cap_en;
    assign if0.ch_data = ch_data;   assign if1.ch_data = ch_data;
    assign if0.exp_en = exp_en;     assign if1.exp_en = exp_en;
    assign if0.exp_data = exp_data; assign if1.exp_data = exp_data;
    assign if0.exp_mask = exp_mask; assign if1.exp_mask = exp_mask;
    assign if0.rd_req = rd_req;     assign if1.rd_req = rd_req;

    slc3_trace_buffer #(.DATA_W(16), .NUM_CH(4), .DEPTH(DEPTH), .CNT_W(16), .WRAP(0))
        u0 (.Clk(Clk), .Reset(Reset), .bus(if0));
    slc3_trace_buffer #(.DATA_W(16), .NUM_CH(4), .DEPTH(DEPTH), .CNT_W(2), .WRAP(1))
        u1 (.Clk(Clk), .Reset(Reset), .bus(if1));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Apply the rules of the block to the inputs sampled at this edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] ts_now;
            logic [3:0]  mm;
            int          maxc;
            ent_t        e;
            maxc = (k == 0) ? 65535 : 3;
            m_rv[k] = 1'b0;
            if (Reset) begin
                m_state[k] = 0; m_q[k].delete(); m_wrapped[k] = 1'b0; m_cnt[k] = 0;
                m_errch[k] = '0; m_ts[k] = '0; m_rdata[k] = '0; m_rts[k] = '0;
                continue;
            end
            ts_now = m_ts[k];
            if (arm && m_state[k] != 1) begin
                m_ts[k] = '0;
                m_state[k] = 1; m_q[k].delete(); m_wrapped[k] = 1'b0;
                m_cnt[k] = 0; m_errch[k] = '0;
            end else begin
                m_ts[k] = m_ts[k] + 1;
                if (m_state[k] == 1) begin
                    if (cap_en) begin
                        if (m_q[k].size() < DEPTH) begin
                            m_q[k].push_back({ts_now, ch_data});
                            if (k == 0 && m_q[k].size() == DEPTH) m_state[k] = 2;
                        end else if (k == 1) begin
                            void'(m_q[k].pop_front());
                            m_q[k].push_back({ts_now, ch_data});
                            m_wrapped[k] = 1'b1;
                        end
                        if (exp_en) begin
                            mm = '0;
                            for (int c = 0; c < 4; c++)
                                mm[c] = exp_mask[c] && (ch_data[c*16 +: 16] != exp_data[c*16 +: 16]);
                            m_errch[k] = m_errch[k] | mm;
                            if (mm != 0 && m_cnt[k] < maxc) m_cnt[k]++;
                        end
                    end
                    if (stop) m_state[k] = 2;
                end else if (m_state[k] == 2 && rd_req && m_q[k].size() > 0) begin
                    e = m_q[k].pop_front();
                    m_rv[k] = 1'b1;
                    m_rdata[k] = e[63:0];
                    m_rts[k] = e[95:64];
                end
            end
        end
    endtask

    task automatic check_one(input int k, input logic [63:0] lvl, input logic [63:0] ful,
                             input logic [63:0] wrp, input logic [63:0] cnt, input logic [63:0] ech,
                             input logic [63:0] bsy, input logic [63:0] rv, input logic [63:0] rd,
                             input logic [63:0] ts);
        chk($sformatf("u%0d level", k), lvl, 64'(m_q[k].size()));
        chk($sformatf("u%0d full", k), ful, 64'(m_q[k].size() == DEPTH));
        chk($sformatf("u%0d wrapped", k), wrp, 64'(m_wrapped[k]));
        chk($sformatf("u%0d error_cnt", k), cnt, 64'(m_cnt[k]));
        chk($sformatf("u%0d err_ch", k), ech, 64'(m_errch[k]));
        chk($sformatf("u%0d busy", k), bsy, 64'(m_state[k] == 1));
        chk($sformatf("u%0d rd_valid", k), rv, 64'(m_rv[k]));
        if (m_rv[k]) begin
            chk($sformatf("u%0d rd_data", k), rd, m_rdata[k]);
            chk($sformatf("u%0d rd_ts", k), ts, TS_EN ? 64'(m_rts[k]) : 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
        check_one(0, 64'(if0.level), 64'(if0.full), 64'(if0.wrapped), 64'(if0.error_cnt),
                  64'(if0.err_ch), 64'(if0.busy), 64'(if0.rd_valid), if0.rd_data, 64'(if0.rd_ts));
        check_one(1, 64'(if1.level), 64'(if1.full), 64'(if1.wrapped), 64'(if1.error_cnt),
                  64'(if1.err_ch), 64'(if1.busy), 64'(if1.rd_valid), if1.rd_data, 64'(if1.rd_ts));
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("reset rd_data", if0.rd_data, 64'd0);
        chk("reset rd_ts", 64'(if1.rd_ts), 64'd0);
        chk("reset busy", 64'(if0.busy), 64'd0);
        Reset = 1'b0;

        // Three PC samples, then three spaced reads
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cap_en = 1'b1; ch_data = {48'h0, 16'(i)}; tick();
        end
        cap_en = 1'b0;
        chk("basic level", 64'(if0.level), 64'd3);
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; tick(); rd_req = 1'b0;
            chk("basic rd_valid", 64'(if0.rd_valid), 64'd1);
            chk("basic pc", 64'(if0.rd_data[15:0]), 64'(i));
            tick();
        end
        chk("basic level empty", 64'(if0.level), 64'd0);
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        chk("empty rd_valid", 64'(if0.rd_valid), 64'd0);

        // Six IR samples: u0 stops when full, u1 overwrites the oldest
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cap_en = 1'b1; ch_data = {32'h0, 16'(i), 16'h0}; tick();
        end
        cap_en = 1'b0;
        chk("nowrap full", 64'(if0.full), 64'd1);
        chk("nowrap busy", 64'(if0.busy), 64'd0);
        chk("nowrap wrapped", 64'(if0.wrapped), 64'd0);
        chk("wrap wrapped", 64'(if1.wrapped), 64'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; tick();
            chk("nowrap ir", 64'(if0.rd_data[31:16]), 64'(i + 1));
            chk("wrap ir", 64'(if1.rd_data[31:16]), 64'(i + 3));
        end
        rd_req = 1'b0; tick();

        // Checker: IR mismatch twice, MDR mismatch once but masked off
        arm = 1'b1; tick(); arm = 1'b0;
        ch_data = 64'h0004_0003_0002_0001;
        cap_en = 1'b1; exp_en = 1'b1;
        exp_mask = 4'hF;    exp_data = ch_data;                           tick();
        exp_mask = 4'hF;    exp_data = ch_data ^ 64'h0000_0000_0001_0000; tick();
        exp_mask = 4'b0111; exp_data = ch_data ^ 64'h0001_0000_0000_0000; tick();
        exp_mask = 4'hF;    exp_data = ch_data ^ 64'h0000_0000_0100_0000; tick();
        cap_en = 1'b0; exp_en = 1'b0;
        chk("check error_cnt", 64'(if0.error_cnt), 64'd2);
        chk("check err_ch", 64'(if0.err_ch), 64'b0010);

        // Saturation on the 2-bit counter
        arm = 1'b1; tick(); arm = 1'b0;
        cap_en = 1'b1; exp_en = 1'b1; exp_mask = 4'hF; exp_data = ch_data ^ 64'h1;
        for (int i = 0; i < 5; i++) tick();
        cap_en = 1'b0; exp_en = 1'b0;
        chk("sat error_cnt", 64'(if1.error_cnt), 64'd3);
        chk("nosat error_cnt", 64'(if0.error_cnt), 64'd4);

        // Reset in the middle of a capture session
        stop = 1'b1; tick(); stop = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        cap_en = 1'b1; exp_en = 1'b1; tick(); tick();
        cap_en = 1'b0; exp_en = 1'b0;
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("midreset busy", 64'(if1.busy), 64'd0);
        chk("midreset level", 64'(if1.level), 64'd0);
        chk("midreset error_cnt", 64'(if1.error_cnt), 64'd0);

        // Timestamps: samples taken 2 and 7 cycles into the session
        arm = 1'b1; tick(); arm = 1'b0;
        tick(); tick();
        cap_en = 1'b1; ch_data = 64'hA; tick(); cap_en = 1'b0;
        tick(); tick(); tick(); tick();
        cap_en = 1'b1; ch_data = 64'hB; tick(); cap_en = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        rd_req = 1'b1; tick();
        chk("ts first", 64'(if0.rd_ts), TS_EN ? 64'd2 : 64'd0);
        tick(); rd_req = 1'b0;
        chk("ts second", 64'(if0.rd_ts), TS_EN ? 64'd7 : 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            Reset    = ($urandom_range(199) == 0);
            arm      = ($urandom_range(29) == 0);
            stop     = ($urandom_range(19) == 0);
            cap_en   = $urandom_range(1);
            exp_en   = $urandom_range(1);
            exp_mask = 4'($urandom);
            rd_req   = arm ? 1'b0 : 1'($urandom_range(1));
            ch_data  = {$urandom, $urandom};
            exp_data = ch_data;
            for (int c = 0; c < 4; c++)
                if ($urandom_range(3) == 0) exp_data[c*16 + $urandom_range(15)] ^= 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/slc3_trace_buffer.md
# slc3_trace_buffer

Synthesizable, parametrised trace-and-check block for the SLC-3 datapath. It samples NUM_CH watched registers (default PC, IR, MAR, MDR) on a capture strobe into a DEPTH-entry trace memory. It compares each sample against expected values and keeps an on-chip error count. It sits beside the SLC-3 core in the lab toplevel, so register-trace checking can run on hardware as well as in simulation.

## Interface
- DATA_W, 16, width of one watched register
- NUM_CH, 4, number of watched channels; channel 0 occupies the LSBs
- DEPTH, 16, trace entries; must be a power of 2, minimum 2
- CNT_W, 16, width of error_cnt
- WRAP, 0, 0 = stop when full; 1 = circular, overwrite oldest
- Clk  in  1  system clock, all logic on the rising edge
- Reset  in  1  synchronous, active-high
- arm  in  1  start a new capture session
- stop  in  1  end the capture session
- cap_en  in  1  sample strobe (e.g. fetch cycle)
- ch_data  in  NUM_CH*DATA_W  live register values
- exp_en  in  1  expected values valid with cap_en
- exp_data  in  NUM_CH*DATA_W  expected register values
- exp_mask  in  NUM_CH  1 = compare this channel
- rd_req  in  1  pop oldest entry (DONE state only)
- rd_valid  out  1  rd_data valid
- rd_data  out  NUM_CH*DATA_W  popped entry
- rd_ts  out  32  timestamp of popped entry
- level  out  $clog2(DEPTH)+1  entries held
- full  out  1  level == DEPTH
- wrapped  out  1  sticky: at least one entry was overwritten
- error_cnt  out  CNT_W  mismatching samples, saturating
- err_ch  out  NUM_CH  sticky per-channel mismatch flags
- busy  out  1  state == CAPTURE

## Operation
- FSM states:
  - IDLE. On arm, go to CAPTURE. Entering CAPTURE clears level, the pointers, wrapped, error_cnt and err_ch.
  - CAPTURE. On stop, go to DONE. With WRAP=0, a write that makes level == DEPTH also goes to DONE. arm is ignored in this state.
  - DONE. On arm, go to CAPTURE (with the same clears). rd_req is honoured only here.
- Capture: in CAPTURE, cap_en writes ch_data at the write pointer. If not full, level increments.
- Capture when full with WRAP=1: the entry overwrites the oldest, the read pointer advances, and wrapped is set.
- Stop and cap_en in the same cycle: the sample is stored, then the FSM moves to DONE.
- Check: runs when cap_en && exp_en in CAPTURE.
  - Per channel, mismatch = exp_mask[i] && ch_data slice != exp_data slice.
  - Each mismatching channel sets err_ch[i].
  - error_cnt increments by 1 per sample with any mismatch, and saturates at all-ones.
- Readout: in DONE with level > 0, rd_req pops the oldest entry and decrements level.
- Empty readout: rd_req with level == 0 is ignored and rd_valid stays 0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - state: IDLE
  - rd_valid, full, wrapped, busy, err_ch: 0
  - error_cnt, level: 0
  - rd_data, rd_ts: 0
- Write, level, full and error_cnt update at the edge that samples cap_en; outputs reflect it the next cycle.
- Read latency is 1: rd_req in cycle N gives rd_valid=1 with data in cycle N+1, for exactly one cycle.
- Back-to-back rd_req in consecutive cycles is allowed, one pop per cycle.
- Reset mid-session abandons the session: all state returns to reset values on the next edge and memory contents are don't-care.

## Configuration
- SLC3_TRACE_TIMESTAMP_EN defined:
  - A 32-bit free-running cycle counter is cleared on Reset and on entry to CAPTURE.
  - Its value is stored with every entry and returned on rd_ts alongside rd_data.
- Macro undefined: no counter and no timestamp storage; rd_ts is tied to 0.

## Structure
- Package slc3_trace_pkg holds:
  - trace_state_t enum (IDLE, CAPTURE, DONE)
  - default parameter constants
  - TS_W = 32
- One sub-module, slc3_trace_ram: simple dual-port memory with one write port and a registered read port, width NUM_CH*DATA_W (+TS_W when timestamps are enabled), depth DEPTH.
- FSM, pointers, compare and counters live in slc3_trace_buffer.

## Test plan
- Reset, arm, then 3 cap_en with PC = 0x0000, 0x0001, 0x0002, then stop, then 3 rd_req -> level 3 then 0; rd_valid one cycle after each rd_req; PC slices return 0x0000, 0x0001, 0x0002.
- WRAP=0, DEPTH=4: 6 cap_en -> full=1 and state DONE after the 4th; samples 5 and 6 dropped; wrapped=0.
- WRAP=1, DEPTH=4: 6 cap_en with IR = 1..6, then stop, then 4 rd_req -> reads return 3, 4, 5, 6; wrapped=1.
- exp_en on 4 samples with an IR mismatch on 2 and a masked-off MDR mismatch on 1 -> error_cnt=2, err_ch=4'b0010.
- CNT_W=2 with 5 mismatching samples -> error_cnt saturates at 3. Separately: Reset asserted mid-CAPTURE -> busy=0, level=0, error_cnt=0 the next cycle.
- With SLC3_TRACE_TIMESTAMP_EN, cap_en 2 and 7 cycles after entering CAPTURE -> rd_ts returns 2 and 7.
